// File: rtl/ibex_pkg.sv
// ibex_pkg: PMC operation and multi-outstanding access-unit state types.
package ibex_pkg;
  typedef enum logic [1:0] {
    PMC_IDLE = 2'd0,
    PMC_REQ  = 2'd1,
    PMC_WFP  = 2'd2
  } pmc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WFP  = 2'd2
  } pmc_mo_state_e;
endpackage

// File: rtl/ibex_pmu_tag_fifo.sv
// ibex_pmu_tag_fifo: in-order 1-bit tag FIFO (write flag per outstanding request).
module ibex_pmu_tag_fifo #(
  parameter  int unsigned Depth = 2,
  localparam int unsigned PW    = Depth > 1 ? $clog2(Depth) : 1,
  localparam int unsigned CW    = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_data,
  output logic          o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_cnt
);
  logic [Depth-1:0] r_mem;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_mem[r_wptr] <= i_data;
      if (i_push) r_wptr <= nxt(r_wptr);
      if (i_pop) r_rptr <= nxt(r_rptr);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == CW'(Depth);
  assign o_cnt   = r_cnt;
endmodule

// File: rtl/ibex_pmu_counter_mo.sv
// ibex_pmu_counter_mo: multi-outstanding PMC access unit with in-order responses
// and wait-for-pulse with programmable timeout.
module ibex_pmu_counter_mo
  import ibex_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pmc_req_i,
  input  pmc_op_e                 pmc_op_i,
  input  logic                    pmc_we_i,
  input  logic [AddrWidth-1:0]    pmc_addr_i,
  input  logic [DataWidth-1:0]    pmc_wdata_i,
  output logic                    pmc_ready_o,
  output logic                    pmc_resp_valid_o,
  output logic                    pmc_rdata_valid_o,
  output logic [DataWidth-1:0]    pmc_rdata_o,
  output logic                    pmc_err_o,
  output logic                    pmc_timeout_o,
  input  logic [TimeoutWidth-1:0] wfp_timeout_i,
  output pmc_op_e                 counter_op_o,
  input  logic                    counter_gnt_i,
  output logic [AddrWidth-1:0]    counter_addr_o,
  output logic                    counter_we_o,
  output logic [DataWidth-1:0]    counter_wdata_o,
  input  logic                    counter_rvalid_i,
  input  logic [DataWidth-1:0]    counter_rdata_i,
  input  logic                    counter_err_i
);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  pmc_mo_state_e         r_state, w_state_nxt;
  logic [TimeoutWidth-1:0] r_timer;
  logic          w_in_wfp, w_retire, w_pulse, w_tmo, w_allow, w_acc, w_push, w_wfp_acc;
  logic          w_last, w_resp, w_tag, w_empty, w_full;
  logic [CW-1:0] w_cnt;

  ibex_pmu_tag_fifo #(.Depth(MaxOutstanding)) u_tag_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_push (w_push),
    .i_pop  (w_retire),
    .i_data (pmc_we_i),
    .o_data (w_tag),
    .o_empty(w_empty),
    .o_full (w_full),
    .o_cnt  (w_cnt)
  );

  assign w_in_wfp  = r_state == WFP;
  assign w_retire  = counter_rvalid_i && !w_in_wfp && !w_empty;
  assign w_pulse   = counter_rvalid_i && w_in_wfp;
  // A pulse arriving in the timeout cycle takes precedence over the timeout.
  assign w_tmo     = w_in_wfp && !counter_rvalid_i && wfp_timeout_i != '0 && r_timer == wfp_timeout_i;
  assign w_allow   = !w_in_wfp && (pmc_op_i == PMC_WFP ? r_state == IDLE : (!w_full || w_retire));
  assign pmc_ready_o = counter_gnt_i && w_allow;
  assign w_acc     = pmc_req_i && pmc_ready_o;
  assign w_push    = w_acc && pmc_op_i == PMC_REQ;
  assign w_wfp_acc = w_acc && pmc_op_i == PMC_WFP;
  assign w_last    = w_retire && !w_push && w_cnt == CW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_state_nxt  = w_in_wfp ? ((counter_rvalid_i || w_tmo) ? IDLE : WFP) :
                   w_wfp_acc ? WFP : w_push ? BUSY : w_last ? IDLE : r_state;
    counter_op_o = PMC_IDLE;
    counter_op_o = w_in_wfp ? ((counter_rvalid_i || w_tmo) ? PMC_IDLE : PMC_WFP) :
                   (pmc_req_i && w_allow) ? pmc_op_i : PMC_IDLE;
  end

  // Timer holds k in the k-th cycle after WFP accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_wfp_acc ? TimeoutWidth'(1) :
                 (w_in_wfp && !counter_rvalid_i && !w_tmo) ? r_timer + 1'b1 : '0;
    end
  end

  assign w_resp            = w_retire || w_pulse;
  assign pmc_resp_valid_o  = w_resp || w_tmo;
  assign pmc_rdata_valid_o = w_resp && !counter_err_i && (w_pulse || !w_tag);
  assign pmc_rdata_o       = w_resp ? counter_rdata_i : '0;
  assign pmc_err_o         = w_resp && counter_err_i;
  assign pmc_timeout_o     = w_tmo;
  assign counter_addr_o    = pmc_addr_i;
  assign counter_we_o      = pmc_we_i;
  assign counter_wdata_o   = pmc_wdata_i;
endmodule

// File: tb/tb_ibex_pmu_counter_mo.sv
// tb_ibex_pmu_counter_mo: directed scenarios plus random traffic against a queue-based model.
module tb_ibex_pmu_counter_mo;
  import ibex_pkg::*;
  localparam int MAX = 2;

  logic        clk = 0, rst_ni = 0;
  logic        pmc_req_i = 0, pmc_we_i = 0;
  pmc_op_e     pmc_op_i = PMC_REQ;
  logic [31:0] pmc_addr_i = 0, pmc_wdata_i = 0;
  logic        pmc_ready_o, pmc_resp_valid_o, pmc_rdata_valid_o, pmc_err_o, pmc_timeout_o;
  logic [31:0] pmc_rdata_o;
  logic [15:0] wfp_timeout_i = 0;
  pmc_op_e     counter_op_o;
  logic        counter_gnt_i = 0, counter_we_o, counter_rvalid_i = 0, counter_err_i = 0;
  logic [31:0] counter_addr_o, counter_wdata_o, counter_rdata_i = 0;

  int n_tests = 0, n_fail = 0;
  bit q[$];
  bit in_wfp = 0;
  int elapsed = 0;

  ibex_pmu_counter_mo #(.MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pmc_req_i(pmc_req_i), .pmc_op_i(pmc_op_i),
    .pmc_we_i(pmc_we_i), .pmc_addr_i(pmc_addr_i), .pmc_wdata_i(pmc_wdata_i),
    .pmc_ready_o(pmc_ready_o), .pmc_resp_valid_o(pmc_resp_valid_o),
    .pmc_rdata_valid_o(pmc_rdata_valid_o), .pmc_rdata_o(pmc_rdata_o),
    .pmc_err_o(pmc_err_o), .pmc_timeout_o(pmc_timeout_o), .wfp_timeout_i(wfp_timeout_i),
    .counter_op_o(counter_op_o), .counter_gnt_i(counter_gnt_i),
    .counter_addr_o(counter_addr_o), .counter_we_o(counter_we_o),
    .counter_wdata_o(counter_wdata_o), .counter_rvalid_i(counter_rvalid_i),
    .counter_rdata_i(counter_rdata_i), .counter_err_i(counter_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit req, input pmc_op_e op, input bit we, input bit gnt,
                      input bit rv, input logic [31:0] rd, input bit err, input logic [15:0] tmo);
    bit retire, pulse, to, allow, ready;
    pmc_op_e eop;
    @(negedge clk);
    pmc_req_i = req; pmc_op_i = op; pmc_we_i = we; counter_gnt_i = gnt;
    counter_rvalid_i = rv; counter_rdata_i = rd; counter_err_i = err; wfp_timeout_i = tmo;
    pmc_addr_i = $urandom; pmc_wdata_i = $urandom;
    #1;
    retire = rv && !in_wfp && q.size() > 0;
    pulse  = rv && in_wfp;
    to     = in_wfp && !rv && tmo != 0 && elapsed == int'(tmo);
    allow  = !in_wfp && (op == PMC_WFP ? q.size() == 0 : (q.size() < MAX || retire));
    ready  = gnt && allow;
    eop    = in_wfp ? ((rv || to) ? PMC_IDLE : PMC_WFP) : (req && allow) ? op : PMC_IDLE;
    check("ready", pmc_ready_o, ready);
    check("cop", counter_op_o, eop);
    check("resp", pmc_resp_valid_o, retire || pulse || to);
    check("rdv", pmc_rdata_valid_o, (pulse || (retire && !q[0])) && !err);
    check("rdata", pmc_rdata_o, (retire || pulse) ? rd : 32'h0);
    check("err", pmc_err_o, (retire || pulse) && err);
    check("tmo", pmc_timeout_o, to);
    check("pass", {counter_addr_o, counter_wdata_o}, {pmc_addr_i, pmc_wdata_i});
    @(posedge clk);
    if (retire) void'(q.pop_front());
    if (req && ready && op == PMC_REQ) q.push_back(we);
    if (in_wfp) begin
      if (rv || to) in_wfp = 0;
      else elapsed++;
    end else if (req && ready && op == PMC_WFP) begin
      in_wfp = 1;
      elapsed = 1;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    counter_gnt_i = 1;
    #1;
    check("rst_ready", pmc_ready_o, 1);
    check("rst_cop", counter_op_o, PMC_IDLE);
    check("rst_out", {pmc_resp_valid_o, pmc_rdata_valid_o, pmc_err_o, pmc_timeout_o}, 0);
    rst_ni = 1;
    // Single read returning 0xABCD
    step(1, PMC_REQ, 0, 1, 0, 0, 0, 0);
    step(0, PMC_REQ, 0, 1, 1, 32'hABCD, 0, 0);
    // Write, read, blocked third, then full with retire + accept in the same cycle
    step(1, PMC_REQ, 1, 1, 0, 0, 0, 0);
    step(1, PMC_REQ, 0, 1, 0, 0, 0, 0);
    step(1, PMC_REQ, 1, 1, 0, 0, 0, 0);
    step(1, PMC_REQ, 1, 1, 1, 32'h11, 0, 0);
    step(0, PMC_REQ, 0, 1, 1, 32'h22, 0, 0);
    step(0, PMC_REQ, 0, 1, 1, 32'h33, 0, 0);
    step(0, PMC_REQ, 0, 1, 1, 32'h44, 0, 0);
    // WFP timing out at cycle 5, then WFP with pulse at cycle 5
    for (int k = 0; k < 2; k++) begin
      step(1, PMC_WFP, 0, 1, 0, 0, 0, 5);
      repeat (4) step(1, PMC_REQ, 0, 1, 0, 0, 0, 5);
      step(0, PMC_REQ, 0, 1, k[0], 32'h55, 0, 5);
      check("wfp_done", {31'h0, in_wfp}, 0);
    end
    // Read with counter error
    step(1, PMC_REQ, 0, 1, 0, 0, 0, 0);
    step(0, PMC_REQ, 0, 1, 1, 32'h77, 1, 0);
    // Reset with two outstanding, then a stray response
    step(1, PMC_REQ, 0, 1, 0, 0, 0, 0);
    step(1, PMC_REQ, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 0; pmc_req_i = 0; counter_rvalid_i = 1;
    #1;
    check("mid_rst_out", {pmc_resp_valid_o, pmc_rdata_valid_o, pmc_err_o, pmc_timeout_o}, 0);
    check("mid_rst_cop", counter_op_o, PMC_IDLE);
    q.delete(); in_wfp = 0; elapsed = 0;
    @(negedge clk);
    rst_ni = 1;
    step(0, PMC_REQ, 0, 1, 1, 32'h99, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom % 4 != 0, ($urandom % 5 == 0) ? PMC_WFP : PMC_REQ, 1'($urandom),
           $urandom % 4 != 0, $urandom % 3 == 0, $urandom, $urandom % 8 == 0,
           16'($urandom_range(0, 8)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
